// File: rtl/lsu_access_if.sv
// Request, data-bus and response signals of the MEM-stage load/store unit.
// The slave modport is the unit; the master modport is the pipeline plus memory side.
interface lsu_access_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_is_store;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              dbus_valid;
   logic [ADDR_W-1:0] dbus_addr;
   logic [2:0]        dbus_size;
   logic [7:0]        dbus_strobe;
   logic [DATA_W-1:0] dbus_wdata;
   logic              dbus_ok;
   logic [DATA_W-1:0] dbus_rdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_misalign;
   logic              stall;

   modport slave (
      input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
      input  dbus_ok, dbus_rdata, resp_ready,
      output req_ready, dbus_valid, dbus_addr, dbus_size, dbus_strobe, dbus_wdata,
      output resp_valid, resp_data, resp_misalign, stall
   );

   modport master (
      output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
      output dbus_ok, dbus_rdata, resp_ready,
      input  req_ready, dbus_valid, dbus_addr, dbus_size, dbus_strobe, dbus_wdata,
      input  resp_valid, resp_data, resp_misalign, stall
   );
endinterface

// File: rtl/lsu_access.sv
// MEM-stage load/store unit: lane-aligns stores, extends loads, runs a valid/ok
// bus handshake and stalls the pipeline while a transaction is outstanding.
module lsu_access #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic         clk,
   input  logic         reset,
   lsu_access_if.slave  lsu
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q;
   logic              dbus_valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic              store_q;
   logic [7:0]        strobe_q;
   logic [DATA_W-1:0] wdata_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;
   logic              misalign_q;

   logic              misalign_d;
   logic [7:0]        strobe_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] load_d;

   function automatic logic [7:0] base_strobe(input logic [1:0] size);
      case (size)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd1:    return off[0] != 1'b0;
         2'd2:    return off[1:0] != 2'b00;
         2'd3:    return off != 3'b000;
         default: return 1'b0;
      endcase
   endfunction

   // Doubles take the whole lane, so the unsigned flag has no effect there.
   function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] rdata,
                                                     input logic [1:0] size,
                                                     input logic [2:0] off,
                                                     input logic uns);
      logic [DATA_W-1:0] raw;
      raw = rdata >> {off, 3'b000};
      case (size)
         2'd0:    return uns ? {{(DATA_W-8){1'b0}}, raw[7:0]}
                             : {{(DATA_W-8){raw[7]}}, raw[7:0]};
         2'd1:    return uns ? {{(DATA_W-16){1'b0}}, raw[15:0]}
                             : {{(DATA_W-16){raw[15]}}, raw[15:0]};
         2'd2:    return uns ? {{(DATA_W-32){1'b0}}, raw[31:0]}
                             : {{(DATA_W-32){raw[31]}}, raw[31:0]};
         default: return raw;
      endcase
   endfunction

   assign misalign_d = is_misaligned(lsu.req_size, lsu.req_addr[2:0]);
   assign strobe_d   = lsu.req_is_store ? (base_strobe(lsu.req_size) << lsu.req_addr[2:0]) : 8'h00;
   assign wdata_d    = lsu.req_wdata << {lsu.req_addr[2:0], 3'b000};
   assign load_d     = store_q ? '0 : load_extend(lsu.dbus_rdata, size_q, addr_q[2:0], unsigned_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         dbus_valid_q <= 1'b0;
         resp_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         strobe_q     <= 8'h00;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (lsu.req_valid) begin
                  if (misalign_d) begin
                     misalign_q   <= 1'b1;
                     resp_data_q  <= '0;
                     resp_valid_q <= 1'b1;
                     state_q      <= DONE;
                  end else begin
                     addr_q       <= lsu.req_addr;
                     size_q       <= lsu.req_size;
                     unsigned_q   <= lsu.req_unsigned;
                     store_q      <= lsu.req_is_store;
                     strobe_q     <= strobe_d;
                     wdata_q      <= wdata_d;
                     dbus_valid_q <= 1'b1;
                     state_q      <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (lsu.dbus_ok) begin
                  dbus_valid_q <= 1'b0;
                  resp_data_q  <= load_d;
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               if (lsu.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  misalign_q   <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lsu.req_ready     = (state_q == IDLE);
   assign lsu.stall         = ((state_q == IDLE) && lsu.req_valid) || (state_q == BUSY) ||
                              ((state_q == DONE) && !lsu.resp_ready);
   assign lsu.dbus_valid    = dbus_valid_q;
   assign lsu.dbus_addr     = addr_q;
   assign lsu.dbus_size     = {1'b0, size_q};
   assign lsu.dbus_strobe   = strobe_q;
   assign lsu.dbus_wdata    = wdata_q;
   assign lsu.resp_valid    = resp_valid_q;
   assign lsu.resp_data     = resp_data_q;
   assign lsu.resp_misalign = misalign_q;

endmodule

// File: tb/tb_lsu_access.sv
// Directed bench for lsu_access: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares on every response handshake.
module tb_lsu_access;
   localparam int AW = 64;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lsu_access_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   lsu_access #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .lsu(bus.slave));

   typedef struct packed {
      logic [63:0] data;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=0x%016h expected=none", bus.resp_data);
         end else begin
            e = exp_q.pop_front();
            chk("resp_data", bus.resp_data, e.data);
            chk("resp_misalign", 64'(bus.resp_misalign), 64'(e.mis));
         end
      end
   end

   task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                            input logic [63:0] addr, input logic [63:0] wdata);
      bus.req_is_store = st;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
   endtask

   task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
      drive_req(st, sz, uns, addr, wdata);
      #1;
      chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
      chk("stall_on_req", 64'(bus.stall), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Waits (bounded) for the bus request, checks its fields, then answers after dly cycles.
   task automatic bus_serve(input int dly, input logic [63:0] rdata, input logic [63:0] exp_addr,
                            input logic [2:0] exp_size, input logic [7:0] exp_strb,
                            input logic [63:0] exp_wdata);
      int n = 0;
      while (bus.dbus_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.dbus_valid !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL dbus_valid_timeout actual=0 expected=1");
         return;
      end
      chk("dbus_addr", bus.dbus_addr, exp_addr);
      chk("dbus_size", 64'(bus.dbus_size), 64'(exp_size));
      chk("dbus_strobe", 64'(bus.dbus_strobe), 64'(exp_strb));
      chk("dbus_wdata", bus.dbus_wdata, exp_wdata);
      chk("stall_busy", 64'(bus.stall), 64'd1);
      repeat (dly) begin
         @(posedge clk); #1;
         chk("dbus_valid_hold", 64'(bus.dbus_valid), 64'd1);
         chk("dbus_wdata_hold", bus.dbus_wdata, exp_wdata);
         chk("resp_valid_busy", 64'(bus.resp_valid), 64'd0);
      end
      bus.dbus_rdata = rdata;
      bus.dbus_ok    = 1'b1;
      @(posedge clk); #1;
      bus.dbus_ok    = 1'b0;
      bus.dbus_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
      chk("resp_valid_after_ok", 64'(bus.resp_valid), 64'd1);
      chk("dbus_valid_after_ok", 64'(bus.dbus_valid), 64'd0);
   endtask

   task automatic do_load(input logic [1:0] sz, input logic uns, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp, input int dly);
      exp_q.push_back({exp, 1'b0});
      issue(1'b0, sz, uns, addr, 64'h0);
      bus_serve(dly, rdata, addr, {1'b0, sz}, 8'h00, 64'h0);
      @(posedge clk); #1;
   endtask

   task automatic do_store(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
      exp_q.push_back({64'h0, 1'b0});
      issue(1'b1, sz, 1'b0, addr, wdata);
      bus_serve(0, 64'hFFFF_FFFF_FFFF_FFFF, addr, {1'b0, sz}, exp_strb, exp_wdata);
      @(posedge clk); #1;
   endtask

   task automatic do_misalign(input logic [1:0] sz, input logic [63:0] addr);
      exp_q.push_back({64'h0, 1'b1});
      issue(1'b0, sz, 1'b0, addr, 64'h0);
      chk("mis_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("mis_flag", 64'(bus.resp_misalign), 64'd1);
      chk("mis_dbus_valid", 64'(bus.dbus_valid), 64'd0);
      @(posedge clk); #1;
      chk("mis_dbus_valid_after", 64'(bus.dbus_valid), 64'd0);
      chk("mis_req_ready_after", 64'(bus.req_ready), 64'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin : stim
      reset            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.dbus_ok      = 1'b0;
      bus.dbus_rdata   = '0;
      bus.resp_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dbus_valid", 64'(bus.dbus_valid), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_misalign", 64'(bus.resp_misalign), 64'd0);
      chk("rst_strobe", 64'(bus.dbus_strobe), 64'd0);
      chk("rst_addr", bus.dbus_addr, 64'd0);
      chk("rst_wdata", bus.dbus_wdata, 64'd0);
      chk("rst_resp_data", bus.resp_data, 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_stall", 64'(bus.stall), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      do_load(2'd2, 1'b0, 64'h1004, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 2);
      do_store(2'd0, 64'h2003, 64'h0000_0000_0000_00AB, 8'h08, 64'h0000_0000_AB00_0000);
      do_load(2'd1, 1'b1, 64'h3006, 64'hFEDC_0000_0000_0000, 64'h0000_0000_0000_FEDC, 0);
      do_load(2'd1, 1'b0, 64'h3006, 64'hFEDC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FEDC, 1);
      do_misalign(2'd3, 64'h4004);
      do_misalign(2'd1, 64'h5001);
      do_load(2'd0, 1'b0, 64'h7005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0);
      do_load(2'd3, 1'b1, 64'h6008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
      do_store(2'd2, 64'h8004, 64'h0000_0000_1122_3344, 8'hF0, 64'h1122_3344_0000_0000);
      do_store(2'd1, 64'h8006, 64'hFFFF_FFFF_FFFF_1234, 8'hC0, 64'h1234_0000_0000_0000);
      do_store(2'd3, 64'h9000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);

      // Backpressure in DONE with a new request waiting.
      exp_q.push_back({64'h0000_0000_1234_5678, 1'b0});
      issue(1'b0, 2'd2, 1'b0, 64'hA000, 64'h0);
      bus.resp_ready = 1'b0;
      bus_serve(1, 64'h0000_0000_1234_5678, 64'hA000, 3'd2, 8'h00, 64'h0);
      drive_req(1'b1, 2'd0, 1'b0, 64'hB001, 64'h5A);
      repeat (3) begin
         #1;
         chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
         chk("bp_resp_data", bus.resp_data, 64'h0000_0000_1234_5678);
         chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
         chk("bp_stall", 64'(bus.stall), 64'd1);
         @(posedge clk); #1;
      end
      exp_q.push_back({64'h0, 1'b0});
      bus.resp_ready = 1'b1;
      #1;
      chk("bp_stall_release", 64'(bus.stall), 64'd0);
      @(posedge clk); #1;
      chk("bp_idle_req_ready", 64'(bus.req_ready), 64'd1);
      chk("bp_idle_dbus_valid", 64'(bus.dbus_valid), 64'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus_serve(0, 64'h0, 64'hB001, 3'd0, 8'h02, 64'h0000_0000_0000_5A00);
      @(posedge clk); #1;

      // Reset while the bus request is outstanding, then a stray completion.
      issue(1'b0, 2'd3, 1'b0, 64'hC000, 64'h0);
      chk("rb_dbus_valid_busy", 64'(bus.dbus_valid), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rb_dbus_valid", 64'(bus.dbus_valid), 64'd0);
      chk("rb_resp_valid", 64'(bus.resp_valid), 64'd0);
      reset = 1'b1;
      #1;
      chk("rb_req_ready", 64'(bus.req_ready), 64'd1);
      bus.dbus_rdata = 64'h1111_2222_3333_4444;
      bus.dbus_ok    = 1'b1;
      @(posedge clk); #1;
      bus.dbus_ok    = 1'b0;
      chk("rb_late_ok_resp", 64'(bus.resp_valid), 64'd0);
      chk("rb_late_ok_dbus", 64'(bus.dbus_valid), 64'd0);
      chk("rb_late_ok_ready", 64'(bus.req_ready), 64'd1);

      do_load(2'd2, 1'b1, 64'hD008, 64'h0000_0000_8765_4321, 64'h0000_0000_8765_4321, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
